// File: rtl/mat_result_serializer.sv
// -----------------------------------------------------------------------------
// mat_result_serializer
//
// Purpose:
//   Accepts one packed 3x3 product matrix (nine signed elements) and streams it
//   out one element per beat over a valid/ready interface. Each beat carries
//   the element index k = 3*row+col and a last flag on the ninth beat. A new
//   matrix can be accepted on the last beat of the current one, so
//   back-to-back matrices stream without a bubble.
//
// Configuration macro:
//   MAT_SER_TRANSPOSE_EN - when defined, elements are emitted column-major
//                          (k = 0,3,6,1,4,7,2,5,8). When undefined, elements
//                          are emitted row-major and no reordering logic exists.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   in_data holds a matrix to accept
//   in_ready   block can accept a matrix this cycle
//   in_data    packed matrix, element k at in_data[ELEM_W*k +: ELEM_W]
//   out_valid  out_data/out_idx/out_last are valid
//   out_ready  downstream accepts the current beat
//   out_data   current element, bit-exact copy of the stored element
//   out_idx    k of the current element (0..8)
//   out_last   high on the ninth beat of a matrix
//   busy       a matrix is held and not yet fully sent
// -----------------------------------------------------------------------------
module mat_result_serializer #(
    parameter int ELEM_W = 16,
    parameter int DIM    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [9*ELEM_W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ELEM_W-1:0]   out_data,
    output logic [3:0]          out_idx,
    output logic                out_last,
    output logic                busy
);

    // The beat counter, index mapping and packed width all assume a 3x3 matrix.
    generate
        if (DIM != 3) begin : g_dim_check
            $error("mat_result_serializer supports DIM == 3 only");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [3:0]          beat;
    logic [3:0]          beat_next;
    logic [9*ELEM_W-1:0] matrix;
    logic                load;
    logic [3:0]          cur_idx;

    // Maps the beat number to the element index k that is sent on that beat.
    function automatic logic [3:0] beat_to_idx(input logic [3:0] b);
`ifdef MAT_SER_TRANSPOSE_EN
        logic [3:0] k;
        case (b)
            4'd0:    k = 4'd0;
            4'd1:    k = 4'd3;
            4'd2:    k = 4'd6;
            4'd3:    k = 4'd1;
            4'd4:    k = 4'd4;
            4'd5:    k = 4'd7;
            4'd6:    k = 4'd2;
            4'd7:    k = 4'd5;
            4'd8:    k = 4'd8;
            default: k = 4'd0;
        endcase
        return k;
`else
        return b;
`endif
    endfunction

    // State, beat counter and matrix storage. The matrix register only loads
    // on an accept cycle, so in_data is ignored at all other times.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            beat   <= 4'd0;
            matrix <= '0;
        end else begin
            state <= state_next;
            beat  <= beat_next;
            if (load) begin
                matrix <= in_data;
            end
        end
    end

    // Next-state and output logic. Outputs are driven only from registered
    // state, so out_data has no combinational path from in_data. in_ready
    // also rises on the last handshaked beat so the next matrix follows
    // without a gap; reset overrides any accept.
    always_comb begin
        state_next = state;
        beat_next  = beat;
        load       = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        out_last   = 1'b0;
        cur_idx    = 4'd0;
        out_data   = '0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !rst) begin
                    load       = 1'b1;
                    beat_next  = 4'd0;
                    state_next = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                cur_idx   = beat_to_idx(beat);
                out_data  = matrix[cur_idx*ELEM_W +: ELEM_W];
                out_last  = (beat == 4'd8);
                if (out_ready) begin
                    if (beat == 4'd8) begin
                        in_ready = 1'b1;
                        if (in_valid && !rst) begin
                            load      = 1'b1;
                            beat_next = 4'd0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        beat_next = beat + 4'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (rst) begin
            in_ready = 1'b0;
        end

        out_idx = cur_idx;
    end

endmodule

// File: tb/tb_mat_result_serializer.sv
// -----------------------------------------------------------------------------
// tb_mat_result_serializer
//
// Drives mat_result_serializer with directed scenarios followed by randomized
// traffic. A behavioural model holds a queue of expected beats: every accepted
// matrix enqueues its nine (data, index, last) beats in emission order, and
// every downstream handshake dequeues one. A compare process checks the DUT
// against the queue head on every falling edge. Literal expectations from
// hand-worked examples pin the model.
// -----------------------------------------------------------------------------
module tb_mat_result_serializer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [143:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_data;
    logic [3:0]   out_idx;
    logic         out_last;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit model_en = 1'b0;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    beat_t       exp_q[$];
    logic [15:0] seen_data[$];
    logic [3:0]  seen_idx[$];
    logic        seen_last[$];
    int          seen_cyc[$];

    mat_result_serializer #(.ELEM_W(16), .DIM(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Emission order: row-major by default, column-major when transposed.
    function automatic int order_of(input int b);
`ifdef MAT_SER_TRANSPOSE_EN
        return (b % 3) * 3 + (b / 3);
`else
        return b;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process and model update. The model state after the update
    // describes what the DUT must present after the next rising edge.
    always @(negedge clk) begin
        if (model_en) begin
            logic exp_ready;
            logic out_fire;
            logic in_fire;
            exp_ready = !rst && (exp_q.size() == 0 || (exp_q.size() == 1 && out_ready));
            checkOutput("in_ready",  {31'd0, in_ready},  {31'd0, exp_ready});
            checkOutput("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            checkOutput("busy",      {31'd0, busy},      {31'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                checkOutput("out_data", {16'd0, out_data}, {16'd0, exp_q[0].d});
                checkOutput("out_idx",  {28'd0, out_idx},  {28'd0, exp_q[0].k});
                checkOutput("out_last", {31'd0, out_last}, {31'd0, exp_q[0].l});
            end else begin
                checkOutput("out_last_idle", {31'd0, out_last}, 32'd0);
            end

            out_fire = (exp_q.size() != 0) && out_ready;
            in_fire  = in_valid && exp_ready;
            if (rst) begin
                exp_q.delete();
            end else begin
                if (out_fire) begin
                    seen_data.push_back(out_data);
                    seen_idx.push_back(out_idx);
                    seen_last.push_back(out_last);
                    seen_cyc.push_back(cyc);
                    void'(exp_q.pop_front());
                end
                if (in_fire) begin
                    for (int b = 0; b < 9; b++) begin
                        beat_t e;
                        e.k = 4'(order_of(b));
                        e.d = in_data[16*order_of(b) +: 16];
                        e.l = (b == 8);
                        exp_q.push_back(e);
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic iv, input logic [143:0] data, input logic ordy);
        in_valid  = iv;
        in_data   = data;
        out_ready = ordy;
    endtask

    function automatic logic [143:0] junk();
        logic [143:0] m;
        for (int i = 0; i < 9; i++) m[16*i +: 16] = 16'($urandom);
        return m;
    endfunction

    function automatic logic [143:0] ramp(input logic [15:0] base);
        logic [143:0] m;
        for (int i = 0; i < 9; i++) m[16*i +: 16] = base + 16'(i);
        return m;
    endfunction

    function automatic void clear_seen();
        seen_data.delete();
        seen_idx.delete();
        seen_last.delete();
        seen_cyc.delete();
    endfunction

    // Presents a matrix until the DUT accepts it, then scrambles in_data.
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic load_matrix(input logic [143:0] m);
        logic got;
        got = 1'b0;
        in_valid = 1'b1;
        in_data  = m;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        if (!got) checkOutput("load_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_data  = junk();
    endtask

    // Waits until n beats were seen; out_ready follows the given mode.
    task automatic wait_beats(input int n, input bit stall);
        int t;
        t = 0;
        while (seen_data.size() < n && t < 200) begin
            if (stall) out_ready = ((t % 3) == 0);
            @(posedge clk);
            #1;
            t++;
        end
        if (seen_data.size() < n) checkOutput("beat_timeout", 32'(seen_data.size()), 32'(n));
        out_ready = 1'b1;
    endtask

    initial begin
        logic [15:0]  exp_seq[9];
        logic [143:0] m;
`ifdef MAT_SER_TRANSPOSE_EN
        exp_seq = '{16'd1, 16'd4, 16'd7, 16'd2, 16'd5, 16'd8, 16'd3, 16'd6, 16'd9};
`else
        exp_seq = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
`endif
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        model_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_out_data",  {16'd0, out_data},  32'd0);
        checkOutput("reset_out_idx",   {28'd0, out_idx},   32'd0);
        checkOutput("reset_busy",      {31'd0, busy},      32'd0);
        @(posedge clk);
        #1;

        $display("[TB] ramp matrix");
        clear_seen();
        out_ready = 1'b1;
        load_matrix(ramp(16'd1));
        wait_beats(9, 1'b0);
        for (int i = 0; i < 9; i++) begin
            checkOutput("ramp_data", {16'd0, seen_data[i]}, {16'd0, exp_seq[i]});
            checkOutput("ramp_last", {31'd0, seen_last[i]}, {31'd0, i == 8});
        end
        @(negedge clk);
        #1;
        checkOutput("ramp_done_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("ramp_done_ready", {31'd0, in_ready},  32'd1);
        @(posedge clk);
        #1;

        $display("[TB] signed extremes");
        clear_seen();
        m = junk();
        m[16*4 +: 16] = 16'hFFF7;
        m[16*8 +: 16] = 16'h8000;
        load_matrix(m);
        wait_beats(9, 1'b0);
        checkOutput("neg9_beat4",  {16'd0, seen_data[4]}, 32'h0000FFF7);
        checkOutput("min_beat8",   {16'd0, seen_data[8]}, 32'h00008000);
        checkOutput("idx8_beat8",  {28'd0, seen_idx[8]},  32'd8);

        $display("[TB] stalled output");
        clear_seen();
        load_matrix(ramp(16'd1));
        wait_beats(9, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("stall_count", 32'(seen_data.size()), 32'd9);
        for (int i = 0; i < 9; i++)
            checkOutput("stall_data", {16'd0, seen_data[i]}, {16'd0, exp_seq[i]});

        $display("[TB] back-to-back");
        clear_seen();
        load_matrix(ramp(16'd1));
        load_matrix(ramp(16'h0100));
        wait_beats(18, 1'b0);
        checkOutput("b2b_contiguous", 32'(seen_cyc[17] - seen_cyc[0]), 32'd17);
        checkOutput("b2b_first_b",    {16'd0, seen_data[9]}, 32'h00000100);
        checkOutput("b2b_last_a",     {31'd0, seen_last[8]}, 32'd1);

        $display("[TB] reset mid-matrix");
        clear_seen();
        load_matrix(ramp(16'd1));
        wait_beats(4, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rstmid_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rstmid_idx",   {28'd0, out_idx},   32'd0);
        checkOutput("rstmid_busy",  {31'd0, busy},      32'd0);
        checkOutput("rstmid_ready", {31'd0, in_ready},  32'd1);
        @(posedge clk);
        #1;
        clear_seen();
        load_matrix(ramp(16'd1));
        wait_beats(9, 1'b0);
        checkOutput("reload_idx0",  {28'd0, seen_idx[0]},  32'd0);
        checkOutput("reload_data0", {16'd0, seen_data[0]}, 32'd1);

        $display("[TB] randomized traffic");
        for (int t = 0; t < 1500; t++) begin
            applyStimulus(1'($urandom_range(0, 1)), junk(), 1'($urandom_range(0, 3) != 0));
            rst = ($urandom_range(0, 99) == 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("drain_valid", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mat_result_serializer.md
Name: mat_result_serializer

Overview:
- Consumes one packed 3x3 product matrix: 9 signed 16-bit elements in a 144-bit word, as produced by the matrix multiplier.
- Streams the matrix out one element per beat over a valid/ready interface, with an element index and a last flag.
- Sits between the combinational multiplier and downstream narrow consumers (accumulator, output port, memory writer).
- Single clock; reset is synchronous and active-high.

Parameters:
- ELEM_W, 16, width of one matrix element in bits. Packed input width is 9*ELEM_W.
- DIM, 3, matrix dimension. Fixed at 3 for this block; any other value is a compile-time error.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  in_data holds a matrix to accept
- in_ready  output  1  block can accept a matrix this cycle
- in_data  input  144  packed matrix; element k = in_data[16k+15:16k], k = 3*row+col
- out_valid  output  1  out_data/out_idx/out_last are valid
- out_ready  input  1  downstream accepts the current beat
- out_data  output  16  current element, signed two's complement, bit-exact copy
- out_idx  output  4  k of the current element (0..8)
- out_last  output  1  high on the 9th beat of a matrix
- busy  output  1  matrix held and not yet fully sent

Behaviour:
- Reset values: state IDLE, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0. in_ready=0 while rst is high.
- Storage: one 144-bit matrix register, one 4-bit beat counter (0..8), one state bit.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, capture in_data, clear the beat counter, go to SEND.
  - SEND: out_valid=1, busy=1. out_idx = order(beat); out_data = matrix element at out_idx.
- Beat advance: on out_valid&&out_ready with beat<8, beat increments. With no handshake, all out_* are held stable (no glitching of data or index while stalled).
- Final beat: on out_valid&&out_ready with beat==8 (out_last=1), the matrix is complete.
  - If in_valid is also high that cycle, accept the new matrix and stay in SEND with beat=0.
  - Otherwise return to IDLE.
- in_ready = (state==IDLE) || (state==SEND && out_valid && out_ready && out_last), forced to 0 during rst. This is a combinational path from out_ready to in_ready and is permitted.
- Latency: element 0 is presented the cycle after input acceptance. Throughput is 9 cycles per matrix with out_ready held high; back-to-back matrices have no bubble.
- out_data must be a registered value or a mux of registered state only; no combinational path from in_data to out_data.
- in_data is sampled only on an accept cycle. Changes on in_data at any other time have no effect.
- Reset mid-matrix: the held matrix is discarded, the next cycle is IDLE, and no partial continuation occurs.
- out_ready high while out_valid=0 has no effect.
- Default order(b) = b, i.e. row-major, k = 0..8.

Optional Feature:
- Macro: MAT_SER_TRANSPOSE_EN.
- Defined: emit column-major. order(b) gives k = 0,3,6,1,4,7,2,5,8 for b = 0..8. out_idx still reports the true k = 3*row+col. out_last remains on beat 8, where k=8 in both modes.
- Undefined: row-major order only; no transpose logic is synthesized.

Test Plan:
- Reset, then load a matrix with element k = k+1 and out_ready=1 -> beats out_data = 1..9, out_idx = 0..8, out_last only on data 9, then out_valid=0 and in_ready=1.
- Element 4 = 16'hFFF7 (-9), element 8 = 16'h8000 -> same 16-bit values appear on beats 4 and 8, no sign or width alteration.
- out_ready toggles 1,0,0,1,... -> each element appears exactly once, out_data/out_idx stable during the 0 cycles, total 9 accepted beats.
- Two matrices (A: k+1, B: 16'h0100+k) presented back-to-back with out_ready=1 -> in_ready pulses on A's last beat, B's element 0 (16'h0100) follows the next cycle, 18 contiguous beats.
- rst asserted after beat 3 of a matrix -> next cycle out_valid=0, out_idx=0, busy=0, in_ready=1; a reload restarts at k=0.
- With MAT_SER_TRANSPOSE_EN and element k = k+1 -> out_data sequence 1,4,7,2,5,8,3,6,9, out_idx 0,3,6,1,4,7,2,5,8, out_last on out_idx 8.
